// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM state type and count-width helper.
package fifo_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } pack_state_e;

  // Width needed to hold a lane count in the range 0..pack_ratio inclusive.
  function automatic int count_width(input int pack_ratio);
    return $clog2(pack_ratio + 1);
  endfunction

  localparam int DEFAULT_PACK_RATIO = 4;
  localparam int DEFAULT_COUNT_W    = count_width(DEFAULT_PACK_RATIO);

endpackage

// File: rtl/fifo_read_packer_if.sv
// FIFO read port plus packed-word valid/ready output of the read-side packer.
interface fifo_read_packer_if
  import fifo_pkg::*;
#(
  parameter int data_width = 4,
  parameter int pack_ratio = 4
) ();

  localparam int count_w = count_width(pack_ratio);

  logic                             fifo_empty;
  logic [data_width-1:0]            fifo_data;
  logic                             fifo_rd_en;
  logic [data_width*pack_ratio-1:0] out_data;
  logic [count_w-1:0]               out_count;
  logic                             out_valid;
  logic                             out_ready;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_data, out_count, out_valid
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_data, out_count, out_valid
  );

endinterface

// File: rtl/fifo_flush_timer.sv
// Idle timer for partial-word flush; exists only when FIFO_READ_PACKER_FLUSH_EN is defined.
`ifdef FIFO_READ_PACKER_FLUSH_EN
module fifo_flush_timer #(
  parameter int flush_timeout = 15
) (
  input  logic rd_clk,
  input  logic rd_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int cnt_w = $clog2(flush_timeout + 1);
  localparam logic [cnt_w-1:0] load_val = cnt_w'(flush_timeout - 1);

  logic [cnt_w-1:0] count_q, count_d;

  // Down-counter: expire fires on the flush_timeout-th consecutive enabled cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = load_val;
    end else if (enable && count_q != '0) begin
      count_d = count_q - cnt_w'(1);
    end
    expire = enable && !clear && (count_q == '0);
  end

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      count_q <= load_val;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/fifo_read_packer.sv
// Drains narrow FIFO words and packs pack_ratio of them into one wide valid/ready word.
// Optional partial-word flush after an idle timeout: FIFO_READ_PACKER_FLUSH_EN.
module fifo_read_packer
  import fifo_pkg::*;
#(
  parameter int data_width    = 4,
  parameter int pack_ratio    = 4,
  parameter int flush_timeout = 15
) (
  input logic                rd_clk,
  input logic                rd_reset,
  fifo_read_packer_if.master bus
);

  localparam int count_w = count_width(pack_ratio);
  localparam int word_w  = data_width * pack_ratio;
  localparam logic [count_w-1:0] full_count = count_w'(pack_ratio);

  pack_state_e        state_q, state_d;
  logic [count_w-1:0] captured_q, captured_d;
  logic               inflight_q, inflight_d;
  logic [word_w-1:0]  lanes_q, lanes_d;
  logic [word_w-1:0]  out_data_q, out_data_d;
  logic [count_w-1:0] out_count_q, out_count_d;
  logic               out_valid_q, out_valid_d;
  logic               rd_en;
  logic               flush_expire;

  // Gated by reset so the strobe drops immediately, not at the next edge.
  always_comb begin
    rd_en = rd_reset && (state_q == COLLECT) && !bus.fifo_empty &&
            ((int'(captured_q) + int'(inflight_q)) < pack_ratio);
  end

`ifdef FIFO_READ_PACKER_FLUSH_EN
  logic idle_en;
  logic idle_clr;

  always_comb begin
    idle_en  = (state_q == COLLECT) && (captured_q != '0) &&
               (captured_q < full_count) && !inflight_q && bus.fifo_empty;
    idle_clr = rd_en || inflight_q || (state_q != COLLECT) || (captured_q == '0);
  end

  fifo_flush_timer #(
    .flush_timeout(flush_timeout)
  ) u_flush_timer (
    .rd_clk  (rd_clk),
    .rd_reset(rd_reset),
    .clear   (idle_clr),
    .enable  (idle_en),
    .expire  (flush_expire)
  );
`else
  assign flush_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    captured_d  = captured_q;
    inflight_d  = rd_en;
    lanes_d     = lanes_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    case (state_q)
      COLLECT: begin
        if (inflight_q) begin
          lanes_d[int'(captured_q)*data_width +: data_width] = bus.fifo_data;
          captured_d = captured_q + count_w'(1);
        end
        // The last capture and the move to OUTPUT share one edge.
        if (captured_d == full_count) begin
          state_d     = OUTPUT;
          out_data_d  = lanes_d;
          out_count_d = full_count;
          out_valid_d = 1'b1;
        end else if (flush_expire) begin
          state_d     = OUTPUT;
          out_data_d  = lanes_q;
          out_count_d = captured_q;
          out_valid_d = 1'b1;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          state_d     = COLLECT;
          captured_d  = '0;
          lanes_d     = '0;
          out_data_d  = '0;
          out_count_d = '0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      state_q     <= COLLECT;
      captured_q  <= '0;
      inflight_q  <= 1'b0;
      lanes_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      captured_q  <= captured_d;
      inflight_q  <= inflight_d;
      lanes_q     <= lanes_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_data   = out_data_q;
  assign bus.out_count  = out_count_q;
  assign bus.out_valid  = out_valid_q;

endmodule
